// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
module alu_arbiter #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             owner_q, owner_d;
  logic [XLEN-1:0]  lat_a_q, lat_a_d;
  logic [XLEN-1:0]  lat_b_q, lat_b_d;
  logic [3:0]       lat_op_q, lat_op_d;
  logic [XLEN-1:0]  resp_data_d;
  logic             resp_zero_d, resp_err_d;
  logic [CNT_W-1:0] ops_done_d;
  logic             resp0_valid_d, resp1_valid_d, busy_d;
  logic             grant0, grant1;
  logic [3:0]       sel_op;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110, 4'b1001: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  // ALU is fed only from the latched operands, never straight from a requester
  assign alu_a    = lat_a_q;
  assign alu_b    = lat_b_q;
  assign alu_ctrl = lat_op_q;

  // Arbitration: a lone requester always wins; on contention rr_ptr decides
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !rr_ptr_q);
    grant1     = req1_valid && (!req0_valid ||  rr_ptr_q);
    sel_op     = grant1 ? req1_op : req0_op;
    req0_ready = rst_n && (state_q == IDLE) && grant0;
    req1_ready = rst_n && (state_q == IDLE) && grant1;
  end

  // Next-state and next-register values
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    lat_a_d     = lat_a_q;
    lat_b_d     = lat_b_q;
    lat_op_d    = lat_op_q;
    resp_data_d = resp_data;
    resp_zero_d = resp_zero;
    resp_err_d  = resp_err;
    ops_done_d  = ops_done;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d  = grant1;
          lat_a_d  = grant1 ? req1_a : req0_a;
          lat_b_d  = grant1 ? req1_b : req0_b;
          lat_op_d = sel_op;
          if (op_legal(sel_op)) begin
            state_d = EXEC;
          end else begin
            // Illegal ops skip the ALU and answer with an error response
            state_d     = RESP;
            resp_data_d = '0;
            resp_zero_d = 1'b0;
            resp_err_d  = 1'b1;
          end
        end
      end
      EXEC: begin
        resp_data_d = alu_result;
        resp_zero_d = alu_zero;
        resp_err_d  = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (owner_q ? resp1_ready : resp0_ready) begin
          if (ops_done != {CNT_W{1'b1}}) ops_done_d = ops_done + CNT_W'(1);
          rr_ptr_d = !owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    resp0_valid_d = (state_d == RESP) && !owner_d;
    resp1_valid_d = (state_d == RESP) &&  owner_d;
    busy_d        = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      lat_a_q     <= '0;
      lat_b_q     <= '0;
      lat_op_q    <= '0;
      resp_data   <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      ops_done    <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lat_a_q     <= lat_a_d;
      lat_b_q     <= lat_b_d;
      lat_op_q    <= lat_op_d;
      resp_data   <= resp_data_d;
      resp_zero   <= resp_zero_d;
      resp_err    <= resp_err_d;
      ops_done    <= ops_done_d;
      resp0_valid <= resp0_valid_d;
      resp1_valid <= resp1_valid_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a behavioural ALU and reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [63:0] resp_data;
  logic        resp_zero, resp_err;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        busy;
  logic [15:0] ops_done;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_ops = '0;
  int          model_rr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .ops_done(ops_done)
  );

  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[5:0];
      4'b0101: return a >> b[5:0];
      4'b0110: return a - b;
      4'b1001: return 64'($signed(a) >>> b[5:0]);
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1001};
  endfunction

  // Behavioural stand-in for the shared ALU instance
  assign alu_result = ref_result(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == 64'd0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int who, input logic v, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] op);
    if (who == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  function automatic logic rv(input int who);
    return (who == 0) ? resp0_valid : resp1_valid;
  endfunction

  function automatic logic rq(input int who);
    return (who == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic finish_resp(input int who);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    if (model_ops != 16'hFFFF) model_ops++;
    model_rr = 1 - who;
    chk("resp_clear", rv(who), 0);
    chk("busy_idle", busy, 0);
    chk("ops_done", ops_done, model_ops);
  endtask

  // One request by a lone requester, response held for `hold` extra cycles
  task automatic run_op(input int who, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op, input int hold);
    bit          legal;
    logic [63:0] exp_d;
    int          lat;
    legal = ref_legal(op);
    exp_d = legal ? ref_result(a, b, op) : 64'd0;
    @(negedge clk);
    drive_req(who, 1'b1, a, b, op);
    #1;
    chk("req_ready", rq(who), 1);
    chk("other_ready", rq(1 - who), 0);
    @(posedge clk); #1;
    drive_req(who, 1'b0, '0, '0, '0);
    lat = 0;
    while (!rv(who) && lat < 8) begin
      chk("busy_exec", busy, 1);
      chk("exec_ready", rq(who), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), legal ? 64'd1 : 64'd0);
    chk("resp_valid", rv(who), 1);
    chk("other_resp", rv(1 - who), 0);
    chk("resp_data", resp_data, exp_d);
    chk("resp_zero", resp_zero, (legal && exp_d == 64'd0) ? 64'd1 : 64'd0);
    chk("resp_err", resp_err, legal ? 64'd0 : 64'd1);
    chk("alu_ctrl", alu_ctrl, 64'(op));
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    drive_req(1 - who, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0010);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rv(who), 1);
      chk("hold_data", resp_data, exp_d);
      chk("hold_ready0", req0_ready, 0);
      chk("hold_ready1", req1_ready, 0);
    end
    drive_req(1 - who, 1'b0, '0, '0, '0);
    finish_resp(who);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] legal_ops [8];
    logic [3:0] op;
    int         w;
    legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1001};

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_resp0", resp0_valid, 0);
    chk("rst_resp1", resp1_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simple ADD on req0
    run_op(0, 64'd10, 64'd20, 4'b0010, 0);
    // SUB to zero on req1, which also leaves rr_ptr at 0
    run_op(1, 64'd5, 64'd5, 4'b0110, 0);

    // Both continuously valid: grants alternate starting with req0
    @(negedge clk);
    drive_req(0, 1'b1, 64'd20, 64'd10, 4'b0110);
    drive_req(1, 1'b1, 64'd12, 64'd10, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      w = req1_ready ? 1 : (req0_ready ? 0 : 2);
      chk("grant_rr", 64'(w), 64'(model_rr));
      chk("grant_seq", 64'(w), 64'(k % 2));
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rr_valid", rv(model_rr), 1);
      chk("rr_data", resp_data, (model_rr == 0) ? 64'd10 : 64'd8);
      finish_resp(model_rr);
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);

    // Illegal op, then a legal op clears the error
    run_op(0, 64'd3, 64'd4, 4'b1111, 0);
    run_op(0, 64'd7, 64'd1, 4'b0001, 0);

    // SRA held for five cycles
    run_op(0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd1, 4'b1001, 5);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
      run_op(int'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
             op, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of EXEC
    @(negedge clk);
    drive_req(0, 1'b1, 64'd1, 64'd2, 4'b0010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_req(1, 1'b1, 64'd3, 64'd4, 4'b0010);
    #1;
    chk("mrst_resp0", resp0_valid, 0);
    chk("mrst_resp1", resp1_valid, 0);
    chk("mrst_rdy0", req0_ready, 0);
    chk("mrst_rdy1", req1_ready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ops", ops_done, 0);
    chk("mrst_ctrl", alu_ctrl, 0);
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_data", resp_data, 0);
    chk("mrst_err", resp_err, 0);
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    model_ops = '0;
    model_rr  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_resp", {resp0_valid, resp1_valid}, 0);
      chk("post_rst_busy", busy, 0);
    end
    @(negedge clk);
    drive_req(0, 1'b1, 64'd1, 64'd1, 4'b0010);
    drive_req(1, 1'b1, 64'd2, 64'd2, 4'b0010);
    #1;
    chk("post_rst_win0", req0_ready, 1);
    chk("post_rst_win1", req1_ready, 0);
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    chk("post_rst_ops", ops_done, model_ops);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
